// File: rtl/toccata_volume_ramp_pkg.sv
// Shared types and constants for the Toccata volume ramp sequencer.
package toccata_pkg;

  localparam int unsigned TOCCATA_ATTEN_W   = 6;
  localparam int unsigned TOCCATA_ATTEN_MAX = 63;

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    FADE_OUT,
    MUTED
  } vol_ramp_state_t;

endpackage

// File: rtl/toccata_volume_ramp_if.sv
// Register-file-to-volume-block control bus; master = register file side, slave = ramp sequencer.
interface toccata_volume_ramp_if
  import toccata_pkg::*;
#(
  parameter int unsigned ATTEN_W = TOCCATA_ATTEN_W
);

  logic               sample_strobe;
  logic               ramp_enable;
  logic [ATTEN_W-1:0] target_atten_left;
  logic               target_mute_left;
  logic [ATTEN_W-1:0] target_atten_right;
  logic               target_mute_right;
  logic [ATTEN_W-1:0] attenuation_left;
  logic               mute_left;
  logic [ATTEN_W-1:0] attenuation_right;
  logic               mute_right;
  logic               busy_left;
  logic               busy_right;

  modport master (
    output sample_strobe, ramp_enable,
    output target_atten_left, target_mute_left,
    output target_atten_right, target_mute_right,
    input  attenuation_left, mute_left, attenuation_right, mute_right,
    input  busy_left, busy_right
  );

  modport slave (
    input  sample_strobe, ramp_enable,
    input  target_atten_left, target_mute_left,
    input  target_atten_right, target_mute_right,
    output attenuation_left, mute_left, attenuation_right, mute_right,
    output busy_left, busy_right
  );

endinterface

// File: rtl/toccata_volume_ramp_chan.sv
// One channel of the volume ramp: state machine plus registered attenuation/mute/busy.
module toccata_volume_ramp_chan
  import toccata_pkg::*;
#(
  parameter int unsigned ATTEN_W = TOCCATA_ATTEN_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_tick,
  input  logic               i_ramp_enable,
  input  logic [ATTEN_W-1:0] i_tgt_atten,
  input  logic               i_tgt_mute,
  output logic [ATTEN_W-1:0] o_atten,
  output logic               o_mute,
  output logic               o_busy
);

  localparam logic [ATTEN_W-1:0] ATTEN_MAX = '1;

  vol_ramp_state_t    r_state;
  vol_ramp_state_t    w_state_eff;
  vol_ramp_state_t    w_state_nxt;
  logic [ATTEN_W-1:0] r_cur;
  logic [ATTEN_W-1:0] w_cur_nxt;
  logic               r_mute;
  logic               w_mute_nxt;
  logic               r_busy;

  always_comb begin
    w_state_eff = r_state;
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_mute_nxt  = r_mute;

    if (!i_ramp_enable) begin
      w_cur_nxt   = i_tgt_mute ? ATTEN_MAX : i_tgt_atten;
      w_mute_nxt  = i_tgt_mute;
      w_state_nxt = i_tgt_mute ? MUTED : IDLE;
    end else begin
      // Target-driven transition first; a coincident tick then steps in the new state's direction.
      case (r_state)
        IDLE: begin
          if (i_tgt_mute)                w_state_eff = FADE_OUT;
          else if (i_tgt_atten != r_cur) w_state_eff = RAMP;
        end
        RAMP: begin
          if (i_tgt_mute) w_state_eff = FADE_OUT;
        end
        FADE_OUT: begin
          if (!i_tgt_mute) w_state_eff = RAMP;
        end
        MUTED: begin
          if (!i_tgt_mute) begin
            w_mute_nxt  = 1'b0;
            w_state_eff = (i_tgt_atten == ATTEN_MAX) ? IDLE : RAMP;
          end
        end
        default: w_state_eff = IDLE;
      endcase

      w_state_nxt = w_state_eff;
      case (w_state_eff)
        RAMP: begin
          if (i_tick) begin
            if (r_cur < i_tgt_atten)      w_cur_nxt = r_cur + 1'b1;
            else if (r_cur > i_tgt_atten) w_cur_nxt = r_cur - 1'b1;
          end
          if (w_cur_nxt == i_tgt_atten) w_state_nxt = IDLE;
        end
        FADE_OUT: begin
          if (i_tick) begin
            if (r_cur == ATTEN_MAX) begin
              w_mute_nxt  = 1'b1;
              w_state_nxt = MUTED;
            end else begin
              w_cur_nxt = r_cur + 1'b1;
            end
          end
        end
        MUTED:   w_cur_nxt = ATTEN_MAX;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MUTED;
      r_cur   <= '1;
      r_mute  <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_mute  <= w_mute_nxt;
      r_busy  <= (w_state_nxt == RAMP) || (w_state_nxt == FADE_OUT);
    end
  end

  assign o_atten = r_cur;
  assign o_mute  = r_mute;
  assign o_busy  = r_busy;

endmodule

// File: rtl/toccata_volume_ramp.sv
// Toccata volume ramp top: shared sample-rate step divider feeding two channel sequencers.
module toccata_volume_ramp
  import toccata_pkg::*;
#(
  parameter int unsigned STEP_SAMPLES = 4,
  parameter int unsigned ATTEN_W      = TOCCATA_ATTEN_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  toccata_volume_ramp_if.slave  bus
);

  localparam int unsigned        DIV_W    = (STEP_SAMPLES > 1) ? $clog2(STEP_SAMPLES) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(STEP_SAMPLES - 1);

  logic [DIV_W-1:0] r_div;
  logic             w_tick;

  assign w_tick = bus.sample_strobe && (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (bus.sample_strobe) begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
    end
  end

  toccata_volume_ramp_chan #(
    .ATTEN_W (ATTEN_W)
  ) u_chan_left (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_tick        (w_tick),
    .i_ramp_enable (bus.ramp_enable),
    .i_tgt_atten   (bus.target_atten_left),
    .i_tgt_mute    (bus.target_mute_left),
    .o_atten       (bus.attenuation_left),
    .o_mute        (bus.mute_left),
    .o_busy        (bus.busy_left)
  );

  toccata_volume_ramp_chan #(
    .ATTEN_W (ATTEN_W)
  ) u_chan_right (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_tick        (w_tick),
    .i_ramp_enable (bus.ramp_enable),
    .i_tgt_atten   (bus.target_atten_right),
    .i_tgt_mute    (bus.target_mute_right),
    .o_atten       (bus.attenuation_right),
    .o_mute        (bus.mute_right),
    .o_busy        (bus.busy_right)
  );

endmodule

// File: tb/tb_toccata_volume_ramp.sv
// Directed bench for toccata_volume_ramp with STEP_SAMPLES = 4 and hand-computed expectations.
module tb_toccata_volume_ramp;
  import toccata_pkg::*;

  localparam int unsigned STEP = 4;
  localparam logic [5:0]  AMAX = 6'(TOCCATA_ATTEN_MAX);

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned n_div = 0;

  toccata_volume_ramp_if #(.ATTEN_W(TOCCATA_ATTEN_W)) bus ();

  toccata_volume_ramp #(
    .STEP_SAMPLES (STEP),
    .ATTEN_W      (TOCCATA_ATTEN_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One strobe pulse followed by one idle clock; the bench tracks the divider phase itself.
  task automatic strobe(output bit ticked);
    ticked = (n_div == STEP - 1);
    n_div  = ticked ? 0 : n_div + 1;
    bus.sample_strobe = 1'b1;
    cyc();
    bus.sample_strobe = 1'b0;
    cyc();
  endtask

  task automatic tick_once();
    bit t;
    t = 1'b0;
    for (int i = 0; i < STEP && !t; i++) strobe(t);
  endtask

  task automatic settle_left(input logic [5:0] lvl);
    bus.ramp_enable       = 1'b0;
    bus.target_atten_left = lvl;
    bus.target_mute_left  = 1'b0;
    cyc();
    bus.ramp_enable = 1'b1;
  endtask

  task automatic test_reset();
    rst_n                  = 1'b0;
    bus.sample_strobe      = 1'b0;
    bus.ramp_enable        = 1'b1;
    bus.target_atten_left  = AMAX;
    bus.target_mute_left   = 1'b1;
    bus.target_atten_right = AMAX;
    bus.target_mute_right  = 1'b1;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    n_checks++; if (bus.attenuation_left !== AMAX) begin n_errors++; $display("FAIL reset_atten_l: got %0d want %0d", bus.attenuation_left, AMAX); end
    n_checks++; if (bus.mute_left !== 1'b1) begin n_errors++; $display("FAIL reset_mute_l: got %0b want 1", bus.mute_left); end
    n_checks++; if (bus.busy_left !== 1'b0) begin n_errors++; $display("FAIL reset_busy_l: got %0b want 0", bus.busy_left); end
    n_checks++; if (bus.attenuation_right !== AMAX) begin n_errors++; $display("FAIL reset_atten_r: got %0d want %0d", bus.attenuation_right, AMAX); end
    n_checks++; if (bus.mute_right !== 1'b1) begin n_errors++; $display("FAIL reset_mute_r: got %0b want 1", bus.mute_right); end
    n_checks++; if (bus.busy_right !== 1'b0) begin n_errors++; $display("FAIL reset_busy_r: got %0b want 0", bus.busy_right); end
  endtask

  task automatic test_unmute_ramp();
    bit t;
    bus.target_atten_left = 6'd60;
    bus.target_mute_left  = 1'b0;
    cyc();
    n_checks++; if (bus.mute_left !== 1'b0) begin n_errors++; $display("FAIL unmute_mute_l: got %0b want 0", bus.mute_left); end
    n_checks++; if (bus.attenuation_left !== AMAX) begin n_errors++; $display("FAIL unmute_hold_63: got %0d want %0d", bus.attenuation_left, AMAX); end
    n_checks++; if (bus.busy_left !== 1'b1) begin n_errors++; $display("FAIL unmute_busy_l: got %0b want 1", bus.busy_left); end
    for (int k = 1; k <= 3; k++) begin
      repeat (STEP - 1) strobe(t);
      n_checks++; if (bus.attenuation_left !== 6'(64 - k)) begin n_errors++; $display("FAIL ramp_pre_tick%0d: got %0d want %0d", k, bus.attenuation_left, 64 - k); end
      strobe(t);
      n_checks++; if (bus.attenuation_left !== 6'(63 - k)) begin n_errors++; $display("FAIL ramp_tick%0d: got %0d want %0d", k, bus.attenuation_left, 63 - k); end
      n_checks++; if (bus.attenuation_right !== AMAX || bus.mute_right !== 1'b1) begin n_errors++; $display("FAIL indep_right%0d: got %0d/%0b want %0d/1", k, bus.attenuation_right, bus.mute_right, AMAX); end
    end
    n_checks++; if (bus.busy_left !== 1'b0) begin n_errors++; $display("FAIL ramp_done_busy: got %0b want 0", bus.busy_left); end
  endtask

  task automatic test_retarget();
    settle_left(6'd10);
    n_checks++; if (bus.attenuation_left !== 6'd10) begin n_errors++; $display("FAIL settle10: got %0d want 10", bus.attenuation_left); end
    bus.target_atten_left = 6'd13;
    tick_once();
    n_checks++; if (bus.attenuation_left !== 6'd11) begin n_errors++; $display("FAIL retarget_a: got %0d want 11", bus.attenuation_left); end
    tick_once();
    n_checks++; if (bus.attenuation_left !== 6'd12) begin n_errors++; $display("FAIL retarget_b: got %0d want 12", bus.attenuation_left); end
    n_checks++; if (bus.busy_left !== 1'b1) begin n_errors++; $display("FAIL retarget_busy: got %0b want 1", bus.busy_left); end
    bus.target_atten_left = 6'd11;
    tick_once();
    n_checks++; if (bus.attenuation_left !== 6'd11) begin n_errors++; $display("FAIL retarget_c: got %0d want 11", bus.attenuation_left); end
    n_checks++; if (bus.busy_left !== 1'b0) begin n_errors++; $display("FAIL retarget_idle: got %0b want 0", bus.busy_left); end
  endtask

  task automatic test_fade_out();
    settle_left(6'd5);
    bus.target_mute_left = 1'b1;
    for (int i = 1; i <= 58; i++) begin
      tick_once();
      n_checks++; if (bus.attenuation_left !== 6'(5 + i) || bus.mute_left !== 1'b0) begin n_errors++; $display("FAIL fade_step%0d: got %0d/%0b want %0d/0", i, bus.attenuation_left, bus.mute_left, 5 + i); end
    end
    n_checks++; if (bus.busy_left !== 1'b1) begin n_errors++; $display("FAIL fade_busy_at63: got %0b want 1", bus.busy_left); end
    tick_once();
    n_checks++; if (bus.mute_left !== 1'b1) begin n_errors++; $display("FAIL fade_mute: got %0b want 1", bus.mute_left); end
    n_checks++; if (bus.attenuation_left !== AMAX) begin n_errors++; $display("FAIL fade_final: got %0d want %0d", bus.attenuation_left, AMAX); end
    n_checks++; if (bus.busy_left !== 1'b0) begin n_errors++; $display("FAIL fade_muted_busy: got %0b want 0", bus.busy_left); end
  endtask

  task automatic test_fade_abort();
    settle_left(6'd25);
    bus.target_mute_left = 1'b1;
    repeat (5) tick_once();
    n_checks++; if (bus.attenuation_left !== 6'd30) begin n_errors++; $display("FAIL abort_at30: got %0d want 30", bus.attenuation_left); end
    bus.target_atten_left = 6'd5;
    bus.target_mute_left  = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      tick_once();
      n_checks++; if (bus.attenuation_left !== 6'(30 - i) || bus.mute_left !== 1'b0) begin n_errors++; $display("FAIL abort_step%0d: got %0d/%0b want %0d/0", i, bus.attenuation_left, bus.mute_left, 30 - i); end
    end
    n_checks++; if (bus.busy_left !== 1'b0) begin n_errors++; $display("FAIL abort_idle: got %0b want 0", bus.busy_left); end
  endtask

  task automatic test_bypass_right();
    bus.ramp_enable        = 1'b0;
    bus.target_atten_right = 6'd20;
    bus.target_mute_right  = 1'b0;
    cyc();
    n_checks++; if (bus.attenuation_right !== 6'd20) begin n_errors++; $display("FAIL bypass_atten_r: got %0d want 20", bus.attenuation_right); end
    n_checks++; if (bus.mute_right !== 1'b0) begin n_errors++; $display("FAIL bypass_mute_r: got %0b want 0", bus.mute_right); end
    n_checks++; if (bus.busy_right !== 1'b0) begin n_errors++; $display("FAIL bypass_busy_r: got %0b want 0", bus.busy_right); end
    bus.target_mute_right = 1'b1;
    cyc();
    n_checks++; if (bus.attenuation_right !== AMAX || bus.mute_right !== 1'b1) begin n_errors++; $display("FAIL bypass_muted_r: got %0d/%0b want %0d/1", bus.attenuation_right, bus.mute_right, AMAX); end
    bus.target_mute_right = 1'b0;
    cyc();
    bus.ramp_enable = 1'b1;
    cyc();
    n_checks++; if (bus.attenuation_right !== 6'd20 || bus.busy_right !== 1'b0) begin n_errors++; $display("FAIL reenable_r: got %0d/%0b want 20/0", bus.attenuation_right, bus.busy_right); end
  endtask

  task automatic test_reset_midramp();
    settle_left(6'd30);
    bus.target_atten_left = 6'd50;
    repeat (10) tick_once();
    n_checks++; if (bus.attenuation_left !== 6'd40 || bus.busy_left !== 1'b1) begin n_errors++; $display("FAIL midramp_at40: got %0d/%0b want 40/1", bus.attenuation_left, bus.busy_left); end
    #2;
    rst_n = 1'b0;
    #1;
    n_div = 0;
    n_checks++; if (bus.attenuation_left !== AMAX || bus.mute_left !== 1'b1) begin n_errors++; $display("FAIL async_rst_l: got %0d/%0b want %0d/1", bus.attenuation_left, bus.mute_left, AMAX); end
    n_checks++; if (bus.busy_left !== 1'b0) begin n_errors++; $display("FAIL async_rst_busy: got %0b want 0", bus.busy_left); end
    n_checks++; if (bus.attenuation_right !== AMAX || bus.mute_right !== 1'b1) begin n_errors++; $display("FAIL async_rst_r: got %0d/%0b want %0d/1", bus.attenuation_right, bus.mute_right, AMAX); end
    bus.target_atten_left  = AMAX;
    bus.target_mute_left   = 1'b1;
    bus.target_atten_right = AMAX;
    bus.target_mute_right  = 1'b1;
    cyc();
    rst_n = 1'b1;
    cyc();
    n_checks++; if (bus.attenuation_left !== AMAX || bus.mute_left !== 1'b1) begin n_errors++; $display("FAIL post_rst_l: got %0d/%0b want %0d/1", bus.attenuation_left, bus.mute_left, AMAX); end
  endtask

  initial begin
    test_reset();
    test_unmute_ramp();
    test_retarget();
    test_fade_out();
    test_fade_abort();
    test_bypass_right();
    test_reset_midramp();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
